// File: rtl/tcbm_drive_link.sv
// ---------------------------------------------------------------------------
// tcbm_drive_link
//   Drive-side end of a 1551-style TCBM parallel link. The host presents a
//   code byte and a second byte using a 4-phase DAV/ACK handshake. Received
//   bytes go to the local drive controller over the rx valid/ready stream.
//   Reply bytes for code 0x83 come back over the tx valid/ready stream.
//   Status bits for the host are driven on st_out.
//
// Ports
//   phi2       clock; all state changes on its rising edge
//   reset      synchronous, active-high reset
//   pa_in      sampled TCBM data bus (host to drive)
//   pa_out     TCBM data bus drive value
//   pa_oe      1 = drive pa_out onto the bus
//   dav_in     host DAV, active low, asynchronous to phi2
//   ack_out    drive ACK, active low
//   st_out     status to host: 00 ok, 01 read timeout, 10 write timeout, 11 EOI
//   rx_data    received byte
//   rx_kind    00 command (0x81), 01 data (0x82), 10 data+EOI (0x84)
//   rx_valid   rx_data/rx_kind valid
//   rx_ready   local side accepts the rx byte
//   tx_data    reply byte for code 0x83
//   tx_status  status sent with the reply byte
//   tx_valid   tx_data/tx_status valid
//   tx_ready   high while the engine waits for a reply byte
//   bad_code   one-cycle pulse when an unknown code byte completes
//   busy       high in every state except IDLE
//
// Parameters
//   SYNC_STAGES  flops synchronising dav_in (minimum 2)
//   TIMEOUT      cycles to wait for the local side (2..65535)
//
// FSM states
//   state      | meaning
//   IDLE       | waiting for DAV low carrying a code byte
//   CODE_ACK   | code byte acknowledged, waiting for DAV high
//   WAIT_BYTE2 | waiting for DAV low of the second byte
//   RX_HOLD    | received byte offered to the local side
//   TX_WAIT    | waiting for the local side to supply a reply byte
//   BYTE2_ACK  | second byte acknowledged, waiting for DAV high
// ---------------------------------------------------------------------------
module tcbm_drive_link #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic       phi2,
  input  logic       reset,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic       dav_in,
  output logic       ack_out,
  output logic [1:0] st_out,
  output logic [7:0] rx_data,
  output logic [1:0] rx_kind,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_status,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       bad_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CODE_ACK   = 3'd1,
    WAIT_BYTE2 = 3'd2,
    RX_HOLD    = 3'd3,
    TX_WAIT    = 3'd4,
    BYTE2_ACK  = 3'd5
  } state_t;

  // Last count value before a timeout is declared.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_RD_TO = 2'b01;
  localparam logic [1:0] ST_WR_TO = 2'b10;
  localparam logic [1:0] ST_EOI   = 2'b11;

  // ---------------------------------------------------------------------
  // DAV synchroniser. It resets to the released (high) level so a reset
  // never looks like the start of a new code byte.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] dav_sync_q;
  logic                   dav_s;

  always_ff @(posedge phi2) begin
    if (reset) begin
      dav_sync_q <= '1;
    end else begin
      dav_sync_q <= {dav_sync_q[SYNC_STAGES-2:0], dav_in};
    end
  end

  assign dav_s = dav_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [7:0]  code_q,     code_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        ack_q,      ack_d;
  logic [7:0]  pa_out_q,   pa_out_d;
  logic        pa_oe_q,    pa_oe_d;
  logic [1:0]  st_q,       st_d;
  logic [7:0]  rx_data_q,  rx_data_d;
  logic [1:0]  rx_kind_q,  rx_kind_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_ready_q, tx_ready_d;
  logic        bad_q,      bad_d;
  logic        busy_q,     busy_d;

  // Code byte decode
  logic       code_write;
  logic       code_read;
  logic [1:0] code_kind;

  always_comb begin
    code_write = 1'b0;
    code_read  = 1'b0;
    code_kind  = 2'b00;
    case (code_q)
      8'h81: begin
        code_write = 1'b1;
        code_kind  = 2'b00;
      end
      8'h82: begin
        code_write = 1'b1;
        code_kind  = 2'b01;
      end
      8'h84: begin
        code_write = 1'b1;
        code_kind  = 2'b10;
      end
      8'h83: begin
        code_read  = 1'b1;
      end
      default: begin
        code_write = 1'b0;
      end
    endcase
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= 8'h00;
      cnt_q      <= 16'd0;
      ack_q      <= 1'b1;
      pa_out_q   <= 8'h00;
      pa_oe_q    <= 1'b0;
      st_q       <= ST_OK;
      rx_data_q  <= 8'h00;
      rx_kind_q  <= 2'b00;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      bad_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      pa_out_q   <= pa_out_d;
      pa_oe_q    <= pa_oe_d;
      st_q       <= st_d;
      rx_data_q  <= rx_data_d;
      rx_kind_q  <= rx_kind_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      bad_q      <= bad_d;
      busy_q     <= busy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    pa_out_d   = pa_out_q;
    pa_oe_d    = pa_oe_q;
    st_d       = st_q;
    rx_data_d  = rx_data_q;
    rx_kind_d  = rx_kind_q;
    rx_valid_d = rx_valid_q;
    tx_ready_d = tx_ready_q;
    bad_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!dav_s) begin
          code_d  = pa_in;
          st_d    = ST_OK;
          ack_d   = 1'b0;
          state_d = CODE_ACK;
        end
      end

      CODE_ACK: begin
        if (dav_s) begin
          ack_d = 1'b1;
          if (code_write || code_read) begin
            state_d = WAIT_BYTE2;
          end else begin
            bad_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WAIT_BYTE2: begin
        if (!dav_s) begin
          cnt_d = 16'd0;
          if (code_read) begin
            tx_ready_d = 1'b1;
            state_d    = TX_WAIT;
          end else begin
            rx_data_d  = pa_in;
            rx_kind_d  = code_kind;
            rx_valid_d = 1'b1;
            state_d    = RX_HOLD;
          end
        end
      end

      RX_HOLD: begin
        // Acceptance is checked first so a hand-off on the terminal count
        // cycle still counts as a successful transfer.
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          st_d       = (rx_kind_q == 2'b10) ? ST_EOI : ST_OK;
          ack_d      = 1'b0;
          state_d    = BYTE2_ACK;
        end else if (cnt_q == CNT_LAST) begin
          rx_valid_d = 1'b0;
          st_d       = ST_WR_TO;
          ack_d      = 1'b0;
          state_d    = BYTE2_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      TX_WAIT: begin
        if (tx_valid) begin
          pa_out_d   = tx_data;
          st_d       = tx_status;
          pa_oe_d    = 1'b1;
          tx_ready_d = 1'b0;
          ack_d      = 1'b0;
          state_d    = BYTE2_ACK;
        end else if (cnt_q == CNT_LAST) begin
          pa_out_d   = 8'h00;
          st_d       = ST_RD_TO;
          pa_oe_d    = 1'b1;
          tx_ready_d = 1'b0;
          ack_d      = 1'b0;
          state_d    = BYTE2_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BYTE2_ACK: begin
        // st_out is left alone: the host reads it after ACK is released.
        if (dav_s) begin
          ack_d   = 1'b1;
          pa_oe_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign pa_out   = pa_out_q;
  assign pa_oe    = pa_oe_q;
  assign ack_out  = ack_q;
  assign st_out   = st_q;
  assign rx_data  = rx_data_q;
  assign rx_kind  = rx_kind_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign bad_code = bad_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tcbm_drive_link.sv
// Testbench for tcbm_drive_link: host-side driver, local-side responders,
// and a scoreboard monitor that checks every ACK edge and rx hand-off.
module tb_tcbm_drive_link;

  localparam int TO = 16;

  logic       phi2 = 1'b0;
  logic       reset;
  logic [7:0] pa_in;
  logic [7:0] pa_out;
  logic       pa_oe;
  logic       dav_in;
  logic       ack_out;
  logic [1:0] st_out;
  logic [7:0] rx_data;
  logic [1:0] rx_kind;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [1:0] tx_status;
  logic       tx_valid;
  logic       tx_ready;
  logic       bad_code;
  logic       busy;

  tcbm_drive_link #(.SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .phi2      (phi2),
    .reset     (reset),
    .pa_in     (pa_in),
    .pa_out    (pa_out),
    .pa_oe     (pa_oe),
    .dav_in    (dav_in),
    .ack_out   (ack_out),
    .st_out    (st_out),
    .rx_data   (rx_data),
    .rx_kind   (rx_kind),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_status (tx_status),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bad_code  (bad_code),
    .busy      (busy)
  );

  always #5 phi2 = ~phi2;

  // typ: 0 = code-byte ACK, 1 = write byte-2 ACK, 2 = read byte-2 ACK
  typedef struct {
    int         typ;
    logic [1:0] st;
    logic       oe;
    logic [7:0] pa;
    int         lat;
  } ack_exp_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] k;
  } rx_exp_t;

  ack_exp_t ack_q[$];
  rx_exp_t  rx_q[$];

  int tests = 0;
  int fails = 0;
  int bad_seen = 0;
  int bad_exp = 0;

  // Local-side behaviour: accept / supply in the n-th cycle, 0 = never.
  int         rx_pol = 0;
  int         tx_pol = 0;
  logic [7:0] tx_d_pol = 8'h00;
  logic [1:0] tx_s_pol = 2'b00;
  int         rcnt = 0;
  int         tcnt = 0;

  // Monitor state
  int   cyc = 0;
  logic m_ack = 1'b1;
  logic m_bad = 1'b0;
  logic m_rxv = 1'b0;
  logic m_txr = 1'b0;
  int   rxv_rise = 0;
  int   txr_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: expected outcome from the protocol rules
  // ---------------------------------------------------------------------
  function automatic logic [1:0] kind_of(input logic [7:0] code);
    if (code == 8'h84) return 2'b10;
    if (code == 8'h82) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit served(input int n);
    return (n >= 1) && (n <= TO);
  endfunction

  // ---------------------------------------------------------------------
  // Local-side responders, driven just after the rising edge
  // ---------------------------------------------------------------------
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge phi2);
      #1;
      if (rx_valid === 1'b1) begin
        rcnt++;
        rx_ready = (rx_pol > 0) && (rcnt >= rx_pol);
      end else begin
        rcnt = 0;
        rx_ready = 1'b0;
      end
    end
  end

  initial begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_status = 2'b00;
    forever begin
      @(posedge phi2);
      #1;
      if (tx_ready === 1'b1) begin
        tcnt++;
        if ((tx_pol > 0) && (tcnt >= tx_pol)) begin
          tx_valid  = 1'b1;
          tx_data   = tx_d_pol;
          tx_status = tx_s_pol;
        end
      end else begin
        tcnt = 0;
        tx_valid = 1'b0;
        tx_data = 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge phi2);
      cyc++;
      if (reset !== 1'b0) begin
        m_ack = 1'b1;
        m_bad = 1'b0;
        m_rxv = 1'b0;
        m_txr = 1'b0;
      end else begin
        if (rx_valid && !m_rxv) rxv_rise = cyc;
        if (tx_ready && !m_txr) txr_rise = cyc;

        if (rx_valid && rx_ready) begin
          if (rx_q.size() == 0) begin
            chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
          end else begin
            rx_exp_t e;
            e = rx_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e.d));
            chk("rx_kind", 32'(rx_kind), 32'(e.k));
          end
        end

        if (m_ack && !ack_out) begin
          if (ack_q.size() == 0) begin
            chk("ack_unexpected", 32'(st_out), 32'hFFFF_FFFF);
          end else begin
            ack_exp_t e;
            e = ack_q.pop_front();
            chk("ack_st_out", 32'(st_out), 32'(e.st));
            chk("ack_pa_oe", 32'(pa_oe), 32'(e.oe));
            chk("ack_rx_valid", 32'(rx_valid), 32'd0);
            if (e.typ == 2) chk("ack_pa_out", 32'(pa_out), 32'(e.pa));
            if (e.typ == 1) chk("wr_latency", 32'(cyc - rxv_rise), 32'(e.lat));
            if (e.typ == 2) chk("rd_latency", 32'(cyc - txr_rise), 32'(e.lat));
          end
        end

        if (!m_ack && ack_out) chk("release_pa_oe", 32'(pa_oe), 32'd0);

        if (bad_code) begin
          if (m_bad) chk("bad_code_width", 32'd2, 32'd1);
          bad_seen++;
        end

        m_ack = ack_out;
        m_bad = bad_code;
        m_rxv = rx_valid;
        m_txr = tx_ready;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Host driver
  // ---------------------------------------------------------------------
  task automatic wait_ack(input logic v);
    int k;
    k = 0;
    while (ack_out !== v && k < 300) begin
      @(negedge phi2);
      k++;
    end
    chk("ack_wait", 32'(ack_out), 32'(v));
  endtask

  task automatic host_byte(input logic [7:0] b, input int hold);
    pa_in  = b;
    dav_in = 1'b0;
    wait_ack(1'b0);
    repeat (hold) @(negedge phi2);
    dav_in = 1'b1;
    wait_ack(1'b1);
  endtask

  task automatic push_ack(input int typ, input logic [1:0] st, input logic oe,
                          input logic [7:0] pa, input int lat);
    ack_exp_t e;
    e.typ = typ;
    e.st  = st;
    e.oe  = oe;
    e.pa  = pa;
    e.lat = lat;
    ack_q.push_back(e);
  endtask

  task automatic do_write(input logic [7:0] code, input logic [7:0] data,
                          input int n, input int hold);
    logic [1:0] k;
    rx_exp_t    r;
    k = kind_of(code);
    push_ack(0, 2'b00, 1'b0, 8'h00, -1);
    if (served(n)) begin
      r.d = data;
      r.k = k;
      rx_q.push_back(r);
      push_ack(1, (k == 2'b10) ? 2'b11 : 2'b00, 1'b0, 8'h00, n);
    end else begin
      push_ack(1, 2'b10, 1'b0, 8'h00, TO);
    end
    rx_pol = n;
    host_byte(code, hold);
    host_byte(data, hold);
    rx_pol = 0;
  endtask

  task automatic do_read(input int n, input logic [7:0] d, input logic [1:0] s,
                         input int hold);
    push_ack(0, 2'b00, 1'b0, 8'h00, -1);
    if (served(n)) push_ack(2, s, 1'b1, d, n);
    else           push_ack(2, 2'b01, 1'b1, 8'h00, TO);
    tx_pol   = n;
    tx_d_pol = d;
    tx_s_pol = s;
    host_byte(8'h83, hold);
    host_byte(8'($urandom_range(0, 255)), hold);
    tx_pol = 0;
  endtask

  task automatic do_bad(input logic [7:0] code, input int hold);
    push_ack(0, 2'b00, 1'b0, 8'h00, -1);
    bad_exp++;
    host_byte(code, hold);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack_out"},  32'(ack_out),  32'd1);
    chk({tag, "_pa_oe"},    32'(pa_oe),    32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int k;
    int op;
    int n;
    int r;
    int hold;
    logic [7:0] code;

    reset  = 1'b1;
    dav_in = 1'b1;
    pa_in  = 8'h00;
    repeat (3) @(negedge phi2);
    check_reset_state("por");
    chk("por_pa_out",   32'(pa_out),   32'd0);
    chk("por_st_out",   32'(st_out),   32'd0);
    chk("por_rx_data",  32'(rx_data),  32'd0);
    chk("por_rx_kind",  32'(rx_kind),  32'd0);
    chk("por_bad_code", 32'(bad_code), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge phi2);

    // Directed cases
    do_write(8'h82, 8'h5A, 3, 1);
    do_write(8'h84, 8'h0D, 1, 0);
    do_read(5, 8'hA7, 2'b00, 2);
    do_read(0, 8'h00, 2'b00, 0);
    do_write(8'h81, 8'h33, 0, 0);
    do_bad(8'h42, 1);
    do_write(8'h81, 8'h99, TO, 0);
    do_read(TO, 8'h3C, 2'b11, 0);

    // Reset while the received byte is on offer
    push_ack(0, 2'b00, 1'b0, 8'h00, -1);
    rx_pol = 0;
    host_byte(8'h81, 0);
    pa_in  = 8'hE1;
    dav_in = 1'b0;
    k = 0;
    while (rx_valid !== 1'b1 && k < 50) begin
      @(negedge phi2);
      k++;
    end
    chk("rst_rx_hold_reached", 32'(rx_valid), 32'd1);
    repeat (2) @(negedge phi2);
    reset  = 1'b1;
    dav_in = 1'b1;
    @(negedge phi2);
    check_reset_state("rst_rx_hold");
    reset = 1'b0;
    repeat (2) @(negedge phi2);
    do_write(8'h81, 8'h17, 2, 0);

    // Reset in BYTE2_ACK of a read, DAV still low
    push_ack(0, 2'b00, 1'b0, 8'h00, -1);
    push_ack(2, 2'b00, 1'b1, 8'hC4, 2);
    tx_pol   = 2;
    tx_d_pol = 8'hC4;
    tx_s_pol = 2'b00;
    host_byte(8'h83, 0);
    pa_in  = 8'h00;
    dav_in = 1'b0;
    wait_ack(1'b0);
    tx_pol = 0;
    @(negedge phi2);
    reset  = 1'b1;
    dav_in = 1'b1;
    @(negedge phi2);
    check_reset_state("rst_byte2_ack");
    reset = 1'b0;
    repeat (2) @(negedge phi2);
    do_write(8'h81, 8'h6E, 1, 0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 5);
      hold = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) @(negedge phi2);
      r = $urandom_range(0, 9);
      if (r < 7)       n = r + 1;
      else if (r == 7) n = TO;
      else if (r == 8) n = TO + 1;
      else             n = 0;
      if (op <= 2) begin
        k = $urandom_range(0, 2);
        code = (k == 0) ? 8'h81 : ((k == 1) ? 8'h82 : 8'h84);
        do_write(code, 8'($urandom_range(0, 255)), n, hold);
      end else if (op <= 4) begin
        do_read(n, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), hold);
      end else begin
        code = 8'($urandom_range(0, 255));
        while (code >= 8'h81 && code <= 8'h84) code = 8'($urandom_range(0, 255));
        do_bad(code, hold);
      end
    end

    repeat (20) @(negedge phi2);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    chk("rx_q_drained",  32'(rx_q.size()),  32'd0);
    chk("bad_code_count", 32'(bad_seen), 32'(bad_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tcbm_drive_link.md
Name: tcbm_drive_link

Overview:
- Drive-side TCBM link engine: the peripheral end of the 1551-style TCBM parallel interface, answering the host-side TPI (port A data, port B status, port C DAV/ACK).
- Decodes host code bytes, runs the two-byte DAV/ACK handshake and returns status bits.
- On the local side it delivers received bytes to the drive controller over a valid/ready stream and takes reply bytes from a second valid/ready stream.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising dav_in (minimum 2).
- TIMEOUT, 4096, cycles to wait for the local side before reporting a timeout status (range 2..65535).

Ports:
- phi2  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pa_in  in  8  sampled TCBM data bus (host to drive).
- pa_out  out  8  TCBM data bus drive value.
- pa_oe  out  1  1 = drive pa_out onto the bus.
- dav_in  in  1  host DAV, active low, asynchronous.
- ack_out  out  1  drive ACK, active low.
- st_out  out  2  status to host: 00 ok, 01 read timeout, 10 write timeout, 11 EOI.
- rx_data  out  8  received byte.
- rx_kind  out  2  00 command (0x81), 01 data (0x82), 10 data+EOI (0x84).
- rx_valid  out  1  rx_data/rx_kind valid.
- rx_ready  in  1  local side accepts the rx byte.
- tx_data  in  8  reply byte for code 0x83.
- tx_status  in  2  status sent with the reply byte.
- tx_valid  in  1  tx_data/tx_status valid.
- tx_ready  out  1  high while the engine waits for a reply byte.
- bad_code  out  1  one-cycle pulse when an unknown code byte completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: ack_out=1, pa_oe=0, pa_out=00, st_out=00, rx_valid=0, rx_data=00, rx_kind=00, tx_ready=0, bad_code=0, busy=0, state IDLE, timeout counter 0.
- Reset is honoured in any state; a host mid-handshake sees ACK released.
- dav_s is dav_in after SYNC_STAGES flops. All outputs are registered.
- States and transitions:
  - IDLE: when dav_s=0, latch code=pa_in, set st_out=00, go CODE_ACK, ack_out=0. ack_out therefore falls on edge SYNC_STAGES+1 after dav_in falls.
  - CODE_ACK: when dav_s=1, set ack_out=1.
    - code 0x81/0x82/0x84 -> WAIT_BYTE2 (write).
    - code 0x83 -> WAIT_BYTE2 (read).
    - any other code -> IDLE with bad_code=1 for one cycle.
  - WAIT_BYTE2, write: when dav_s=0, latch rx_data=pa_in, set rx_kind from code, rx_valid=1, clear counter, go RX_HOLD.
  - WAIT_BYTE2, read: when dav_s=0, tx_ready=1, clear counter, go TX_WAIT.
  - RX_HOLD: rx_valid and rx_data held stable.
    - rx_ready=1: rx_valid=0 next edge; st_out=11 if kind=10, else 00; ack_out=0; go BYTE2_ACK.
    - Counter reaches TIMEOUT-1 with no rx_ready: drop rx_valid, discard the byte, st_out=10, ack_out=0, go BYTE2_ACK.
  - TX_WAIT:
    - tx_valid=1 (tx_ready=1): pa_out=tx_data, st_out=tx_status, pa_oe=1, tx_ready=0, ack_out=0, go BYTE2_ACK.
    - Timeout: pa_out=00, st_out=01, pa_oe=1, tx_ready=0, ack_out=0, go BYTE2_ACK.
  - BYTE2_ACK: when dav_s=1, set ack_out=1, pa_oe=0, go IDLE. st_out holds until the next code byte is latched.
- Simultaneous events: a transfer on the same cycle the counter hits TIMEOUT-1 wins; no timeout is reported.
- Counter: 16 bits, counts only in RX_HOLD/TX_WAIT and saturates at TIMEOUT-1.
- The engine never drives pa_oe outside TX_WAIT->BYTE2_ACK.
- The engine never changes ack_out twice without an intervening dav_s change, which makes the protocol strictly 4-phase.

Test Plan:
- Write: host PA=0x82, DAV low, wait ack low, DAV high, PA=0x5A, DAV low; rx_ready high on the 3rd rx_valid cycle -> rx_data=5A, rx_kind=01, ack low, st_out=00; DAV high -> ack high, IDLE.
- Code 0x84 + data 0x0D with immediate rx_ready -> rx_kind=10, st_out=11.
- Read: code 0x83, then DAV low; tx_valid asserted 5 cycles later with tx_data=0xA7, tx_status=00 -> pa_oe=1, pa_out=A7, ack low; DAV high -> pa_oe=0, ack high.
- Timeouts with TIMEOUT=16:
  - read with tx_valid never asserted -> ack low exactly 16 cycles after tx_ready rises, pa_out=00, st_out=01.
  - write with rx_ready never asserted -> st_out=10, rx_valid drops.
- Code 0x42 -> ack low/high cycle completes, bad_code pulses once, next DAV low is treated as a new code byte.
- Assert reset in RX_HOLD and in BYTE2_ACK of a read -> next edge: ack_out=1, pa_oe=0, rx_valid=0, busy=0; a subsequent 0x81 transfer succeeds.
